// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions: word size, flush value and the stage-register bundle.
// Used by the fetch stage and by the later pipeline stage registers.
package fetch_stage_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
    } if_id_t;

    // Contents of a stage register after reset or flush: a bubble.
    localparam if_id_t IF_ID_EMPTY = '{instr: NOP_INSTR, pc: 32'h0000_0000, valid: 1'b0};

endpackage

// File: rtl/if_id_reg.sv
// Pipeline stage register with reset > flush > freeze > load priority.
// Flush inserts a bubble; freeze holds the current contents.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   freeze,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t stage_r;

    // Stage register update in priority order.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_r <= IF_ID_EMPTY;
        end else if (flush) begin
            stage_r <= IF_ID_EMPTY;
        end else if (freeze) begin
            stage_r <= stage_r;
        end else begin
            stage_r <= d;
        end
    end

    assign q = stage_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and loads IF/ID.
// Also keeps a saturating count of instructions delivered to decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             branch_taken,
    input  logic [31:0]      branch_addr,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_data,
    output logic [31:0]      id_instr,
    output logic [31:0]      id_pc,
    output logic             id_valid,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [31:0]      PC_STEP   = 32'(WORD_BYTES);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

    logic [31:0]      pc_r;
    logic [31:0]      pc_next_s;
    logic [31:0]      pc_plus4_s;
    logic             load_s;
    logic [CNT_W-1:0] count_r;
    if_id_t           stage_in_s;
    if_id_t           stage_out_s;

    assign pc_plus4_s = pc_r + PC_STEP;
    assign load_s     = ~branch_taken & ~freeze;

    // Next PC: branch redirect wins over freeze, otherwise advance one word.
    always_comb begin
        pc_next_s = pc_plus4_s;
        if (branch_taken) begin
            pc_next_s = {branch_addr[31:2], 2'b00};
        end else if (freeze) begin
            pc_next_s = pc_r;
        end else begin
            pc_next_s = pc_plus4_s;
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    // Word presented to IF/ID when it loads.
    always_comb begin
        stage_in_s       = IF_ID_EMPTY;
        stage_in_s.instr = imem_data;
        stage_in_s.pc    = pc_plus4_s;
        stage_in_s.valid = 1'b1;
    end

    if_id_reg u_if_id (
        .clk    (clk),
        .rst    (rst),
        .flush  (branch_taken),
        .freeze (freeze),
        .d      (stage_in_s),
        .q      (stage_out_s)
    );

    // Saturating count of valid loads into IF/ID.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= CNT_ZERO;
        end else if (load_s && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign imem_addr   = pc_r;
    assign id_instr    = stage_out_s.instr;
    assign id_pc       = stage_out_s.pc;
    assign id_valid    = stage_out_s.valid;
    assign fetch_count = count_r;

endmodule
